// File: rtl/sr_bank_scheduler_pkg.sv
// Shared types and helpers for the SR flip-flop bank scheduler.
// The state enum is used by the top-level FSM; idx_width sizes index buses.
package sr_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // A one-entry range still needs a one-bit index bus.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sr_bank_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// The pointer moves past the winner only when the grant is actually taken.
module rr_arbiter
    import sr_bank_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          found;
    int            k;

    // Scan all requesters starting at the pointer, wrapping past N-1.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = PW'(k);
            end
        end
    end

    always_comb begin
        if (grant_idx == PW'(N - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/sr_bank_scheduler.sv
// Shares a bank of SR flip-flops among requesters: one registered S or R pulse
// per granted op, then a readback of Q to confirm it before acknowledging.
module sr_bank_scheduler
    import sr_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IW    = idx_width(NBITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IW-1:0]   idx,
    output logic [NBITS-1:0]     S,
    output logic [NBITS-1:0]     R,
    input  logic [NBITS-1:0]     Q,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic                 busy
);

    localparam int PW = idx_width(NREQ);

    state_t            state;
    state_t            state_next;

    logic [NREQ-1:0]   grant;
    logic [PW-1:0]     grant_idx;
    logic              start;

    logic              req_op;
    logic [IW-1:0]     req_idx;
    logic              req_in_range;

    logic [NREQ-1:0]   gnt_q;
    logic              op_q;
    logic [IW-1:0]     idx_q;
    logic              in_range_q;
    logic              q_bit;

    logic [NBITS-1:0]  sel_next;
    logic [NBITS-1:0]  s_next;
    logic [NBITS-1:0]  r_next;
    logic [NREQ-1:0]   ack_next;
    logic              err_next;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (start),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign start        = (state == IDLE) && (|req);
    assign req_op       = op[grant_idx];
    assign req_idx      = idx[grant_idx*IW +: IW];
    assign req_in_range = int'(req_idx) < NBITS;
    assign q_bit        = |(Q & (NBITS'(1) << idx_q));
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DRIVE;
            DRIVE:   state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // S and R come from one select vector gated by op, so they can never overlap.
    always_comb begin
        sel_next = '0;
        s_next   = '0;
        r_next   = '0;
        ack_next = '0;
        err_next = 1'b0;
        case (state)
            IDLE: begin
                if (start && req_in_range) begin
                    sel_next = NBITS'(1) << req_idx;
                    if (req_op) begin
                        s_next = sel_next;
                    end else begin
                        r_next = sel_next;
                    end
                end
            end
            CHECK: begin
                ack_next = gnt_q;
                err_next = !in_range_q || (q_bit != op_q);
            end
            default: begin
            end
        endcase
    end

    // The op is captured at the grant edge so later changes on op/idx or a dropped req do not affect it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S          <= '0;
            R          <= '0;
            ack        <= '0;
            err        <= 1'b0;
            gnt_q      <= '0;
            op_q       <= 1'b0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
        end else begin
            S   <= s_next;
            R   <= r_next;
            ack <= ack_next;
            err <= err_next;
            if (start) begin
                gnt_q      <= grant;
                op_q       <= req_op;
                idx_q      <= req_idx;
                in_range_q <= req_in_range;
            end
        end
    end

endmodule

// File: tb/tb_sr_bank_scheduler.sv
// Bench for sr_bank_scheduler: directed scenarios plus random traffic checked
// every cycle against a timeline model of grants, pulses and acknowledges.
module tb_sr_bank_scheduler;

    localparam int NREQ = 4;
    localparam int NB   = 8;
    localparam int IW   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   op  = '0;
    logic [NREQ*IW-1:0] idx = '0;
    logic [NB-1:0]     S, R, Q;
    logic [NREQ-1:0]   ack;
    logic              err, busy;

    logic [NB-1:0]     bank   = '0;
    logic [NB-1:0]     stuck0 = '0;

    logic [NREQ-1:0]   req6 = '0;
    logic [NREQ-1:0]   op6  = '0;
    logic [NREQ*3-1:0] idx6 = '0;
    logic [5:0]        s6, r6;
    logic [5:0]        q6 = '0;
    logic [NREQ-1:0]   ack6;
    logic              err6, busy6;

    int checks = 0;
    int errors = 0;
    logic started = 1'b0;

    sr_bank_scheduler #(.NREQ(NREQ), .NBITS(NB), .IW(IW)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
        .S(S), .R(R), .Q(Q), .ack(ack), .err(err), .busy(busy)
    );

    sr_bank_scheduler #(.NREQ(NREQ), .NBITS(6), .IW(3)) dut6 (
        .clk(clk), .rst(rst), .req(req6), .op(op6), .idx(idx6),
        .S(s6), .R(r6), .Q(q6), .ack(ack6), .err(err6), .busy(busy6)
    );

    always #5 clk = ~clk;

    // Real SR bank behaviour, with optional stuck-at-0 outputs for fault scenarios.
    assign Q = bank & ~stuck0;
    always @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (S[i]) bank[i] <= 1'b1;
            else if (R[i]) bank[i] <= 1'b0;
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Timeline model: a grant at edge n fixes outputs for cycles n, n+1, n+2.
    int           n = 0;
    int           free_at = 0;
    int           ptr = 0;
    int           m_id, m_k, m_idx;
    logic         m_op, m_oob;
    logic [NB-1:0]   m_sel;
    logic [NB-1:0]   exp_s [8];
    logic [NB-1:0]   exp_r [8];
    logic [NREQ-1:0] exp_ack [8];
    logic            exp_err [8];
    logic            exp_busy [8];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr = 0;
            free_at = 0;
            for (int i = 0; i < 8; i++) begin
                exp_s[i] = '0; exp_r[i] = '0; exp_ack[i] = '0;
                exp_err[i] = 1'b0; exp_busy[i] = 1'b0;
            end
        end else begin
            n++;
            if (n >= free_at && req != '0) begin
                m_id = -1;
                for (int i = 0; i < NREQ; i++) begin
                    m_k = (ptr + i) % NREQ;
                    if (m_id < 0 && req[m_k]) m_id = m_k;
                end
                m_op  = op[m_id];
                m_idx = int'(idx[m_id*IW +: IW]);
                m_oob = (m_idx >= NB);
                m_sel = m_oob ? '0 : NB'(1) << m_idx;
                exp_s[n % 8]          = m_op ? m_sel : '0;
                exp_r[n % 8]          = m_op ? '0 : m_sel;
                exp_busy[n % 8]       = 1'b1;
                exp_busy[(n + 1) % 8] = 1'b1;
                exp_ack[(n + 2) % 8]  = NREQ'(1) << m_id;
                exp_err[(n + 2) % 8]  = m_oob || (m_op && stuck0[m_idx]);
                ptr     = (m_id + 1) % NREQ;
                free_at = n + 3;
            end
        end
    end

    int cs;
    always @(negedge clk) begin
        if (started) begin
            cs = n % 8;
            check_output("cyc_S", S, exp_s[cs]);
            check_output("cyc_R", R, exp_r[cs]);
            check_output("cyc_ack", ack, exp_ack[cs]);
            check_output("cyc_err", err, exp_err[cs]);
            check_output("cyc_busy", busy, exp_busy[cs]);
            check_output("cyc_S_and_R", S & R, 0);
            check_output("cyc_SR_onehot", ($countones(S | R) <= 1), 1);
            exp_s[cs] = '0; exp_r[cs] = '0; exp_ack[cs] = '0;
            exp_err[cs] = 1'b0; exp_busy[cs] = 1'b0;
        end
    end

    task automatic raise(input int k, input logic o, input int ix);
        req[k] = 1'b1;
        op[k]  = o;
        idx[k*IW +: IW] = IW'(ix);
    endtask

    task automatic wait_cycles(input int c);
        repeat (c) @(negedge clk);
    endtask

    // Requesters hold req until their ack, re-randomising op/idx while waiting.
    task automatic apply_stimulus(input int cycles, input logic allow_new);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) begin
                if (req[k] && ack[k]) begin
                    req[k] = 1'b0;
                end else if (!req[k]) begin
                    if (allow_new && $urandom_range(3) == 0)
                        raise(k, 1'($urandom_range(1)), int'($urandom_range(7)));
                end else if ($urandom_range(3) == 0) begin
                    op[k] = 1'($urandom_range(1));
                    idx[k*IW +: IW] = IW'($urandom_range(7));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        wait_cycles(3);
        check_output("reset_S", S, 0);
        check_output("reset_R", R, 0);
        check_output("reset_ack", ack, 0);
        check_output("reset_err", err, 0);
        check_output("reset_busy", busy, 0);
        rst = 1'b0;
        started = 1'b1;

        raise(1, 1'b1, 3);
        wait_cycles(1);
        check_output("t1_S_pulse", S, 8'h08);
        check_output("t1_busy", busy, 1);
        wait_cycles(1);
        check_output("t1_S_single", S, 8'h00);
        wait_cycles(1);
        check_output("t1_ack", ack, 4'b0010);
        check_output("t1_err", err, 0);
        req[1] = 1'b0;
        wait_cycles(1);
        check_output("t1_ack_drop", ack, 0);
        check_output("t1_Q3", Q[3], 1);

        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        raise(0, 1'b1, 0);
        raise(1, 1'b0, 1);
        raise(2, 1'b1, 2);
        raise(3, 1'b1, 4);
        for (int k = 0; k < NREQ; k++) begin
            wait_cycles(3);
            check_output("t2_rr_order", ack, 64'(1 << k));
            check_output("t2_err", err, 0);
            req[k] = 1'b0;
        end

        wait_cycles(1);
        raise(0, 1'b1, 5);
        raise(2, 1'b0, 5);
        wait_cycles(3);
        check_output("t3_set_first", ack, 4'b0001);
        check_output("t3_set_err", err, 0);
        req[0] = 1'b0;
        wait_cycles(3);
        check_output("t3_clear_second", ack, 4'b0100);
        check_output("t3_clear_err", err, 0);
        req[2] = 1'b0;
        wait_cycles(1);
        check_output("t3_Q5", Q[5], 0);

        stuck0 = 8'h04;
        raise(3, 1'b1, 2);
        wait_cycles(3);
        check_output("t5_ack", ack, 4'b1000);
        check_output("t5_err", err, 1);
        req[3] = 1'b0;
        wait_cycles(1);
        check_output("t5_Q2", Q[2], 0);
        stuck0 = '0;

        req6[0] = 1'b1;
        op6[0]  = 1'b1;
        idx6[2:0] = 3'd7;
        wait_cycles(1);
        check_output("t4_S_none", s6, 0);
        check_output("t4_R_none", r6, 0);
        check_output("t4_busy", busy6, 1);
        wait_cycles(1);
        check_output("t4_SR_none2", s6 | r6, 0);
        wait_cycles(1);
        check_output("t4_ack", ack6, 4'b0001);
        check_output("t4_err", err6, 1);
        req6[0] = 1'b0;
        wait_cycles(1);
        check_output("t4_ack_drop", ack6, 0);
        check_output("t4_err_drop", err6, 0);

        raise(2, 1'b1, 6);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check_output("t6_S_async", S, 0);
        check_output("t6_ack", ack, 0);
        check_output("t6_busy", busy, 0);
        wait_cycles(1);
        rst = 1'b0;
        raise(0, 1'b1, 7);
        wait_cycles(3);
        check_output("t6_first_after_rst", ack, 4'b0001);
        req[0] = 1'b0;
        wait_cycles(3);
        check_output("t6_second_after_rst", ack, 4'b0100);
        req[2] = 1'b0;
        wait_cycles(1);

        stuck0 = 8'h40;
        apply_stimulus(900, 1'b1);
        apply_stimulus(40, 1'b0);
        check_output("drain_idle", req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
